fifo_pack_arbiter: RTL and testbench
====================================

// Module: fifo_pack_arbiter
// PURPOSE
// - Shares the async-FIFO write port among p_num_reqs narrow producers.
// - Round-robin arbitration selects one producer; its message is left-aligned and zero-padded to p_full_bit_width.
// - The packed word is held in a one-entry output register that drives the FIFO push val/rdy handshake.
// - Sits on the fast-clock side, directly ahead of the async FIFO write interface.
// PARAMETERS
// - p_bit_width       3  width of each requester message
// - p_full_bit_width  6  width of the packed FIFO word; must be >= p_bit_width (+ $clog2(p_num_reqs) with tag)
// - p_num_reqs        4  number of requesters, >= 2
// PORTS
// - clk       in   1                           clock; all state on rising edge
// - reset     in   1                           synchronous, active-high reset
// - req_msg   in   p_num_reqs*p_bit_width      flat bus; requester i at [i*p_bit_width +: p_bit_width]
// - req_val   in   p_num_reqs                  per-requester valid
// - req_rdy   out  p_num_reqs                  per-requester ready; at most one bit high (one-hot grant)
// - resp_msg  out  p_full_bit_width            packed word to FIFO write port
// - resp_val  out  1                           packed word valid
// - resp_rdy  in   1                           FIFO not full / accepts word
// BEHAVIOUR
// - Reset values:
//   - resp_val=0, resp_msg=0, req_rdy=0 (combinational, follows rules below), priority pointer ptr=0.
// - Output register state (typedef out_state_t):
//   - EMPTY -> FULL on a grant.
//   - FULL -> EMPTY on resp_val&&resp_rdy with no same-cycle grant.
//   - FULL -> FULL on drain plus grant (back-to-back).
// - can_accept = (state==EMPTY) || resp_rdy. No combinational path req_msg -> resp_msg.
// - Arbitration (combinational):
//   - Scan requesters ptr, ptr+1, ... mod p_num_reqs.
//   - The first i with req_val[i] gets grant[i]=1, qualified by can_accept.
//   - req_rdy = grant, so req_rdy depends on req_val. Producers must not make val depend on rdy.
// - Transfer occurs when req_val[i]&&req_rdy[i]:
//   - Next cycle resp_msg = {req_msg_i, zero pad}; resp_val=1.
//   - Latency is exactly 1 cycle.
// - Pointer update: only on a transfer, ptr <= (i+1) mod p_num_reqs. Wrap from p_num_reqs-1 to 0.
//   - With no transfer, ptr holds. A stalled FIFO therefore never rotates priority.
// - Hold rule: while resp_val && !resp_rdy, resp_msg and resp_val are stable and all req_rdy are 0.
// - No req_val asserted and register drained: resp_val falls to 0 next cycle. resp_msg keeps its last value (don't-care).
// - Fairness: with all requesters continuously valid and resp_rdy=1, grants cycle 0,1,..,N-1,0 with one per cycle.
//   - Worst-case wait is p_num_reqs-1 transfers.
// - Reset mid-operation: a pending word is dropped (resp_val=0 next cycle) and ptr returns to 0.
//   - Requesters see req_rdy=0 during reset.
// - Widths:
//   - Pad width P = p_full_bit_width - p_bit_width.
//   - P==0 is legal (no pad).
//   - A negative P is a static elaboration error ($error).
// CONFIGURATION
// - Macro FIFO_PACK_ARB_SRC_TAG_EN.
// - Defined:
//   - The low $clog2(p_num_reqs) bits of the pad carry the granted index i.
//   - Remaining pad bits are 0.
//   - Elaboration errors if P < $clog2(p_num_reqs).
// - Undefined: the pad is all zeros. This is bit-identical to the plain zero-padding packager.
// STRUCTURE
// - Package fifo_pack_pkg:
//   - out_state_t (EMPTY, FULL).
//   - Function pad_width(full, bit) returns full-bit.
//   - Function tag_width(n) returns $clog2(n).
// - Sub-module fifo_pack_rr_arbiter #(p_num_reqs):
//   - Inputs: clk, reset, req (val), en (can_accept).
//   - Outputs: one-hot grant and grant index.
//   - Owns the ptr register, which updates only when |grant.
// - Top level: pack/pad mux, output register, state update.
// TESTING
// - Reset: hold reset 3 cycles with all req_val=1 -> resp_val=0, resp_msg=0, req_rdy=0. Deassert -> requester 0 granted first.
// - Single requester: N=4, only req 2 valid with msg 3'b101, resp_rdy=1 -> next cycle resp_val=1, resp_msg=6'b101000.
//   - Tag on: resp_msg=6'b101010.
// - Round-robin: all 4 valid with constant msgs 1,2,3,4 and resp_rdy=1 -> resp_msg tops 1,2,3,4,1,... on consecutive cycles with no bubbles.
// - Backpressure: resp_rdy=0 for 5 cycles with word pending -> resp_msg stable, req_rdy=0, ptr unchanged.
//   - Release -> the held word is consumed, then the next grant follows the pre-stall ptr.
// - Wrap/skip: only reqs 3 and 0 valid -> grants alternate 3,0,3,0. Ptr wraps 3->0 correctly.
// - Mid-op reset: reset with resp_val=1, resp_rdy=0 -> word dropped, next grant goes to lowest valid index from 0.

Source files
------------

// File: rtl/fifo_pack_pkg.sv
// Shared types and width helpers for the FIFO write-port packing arbiter.
`timescale 1ns/1ps
package fifo_pack_pkg;

  typedef enum logic {EMPTY, FULL} out_state_t;

  function automatic int pad_width(input int full, input int bits);
    return full - bits;
  endfunction

  function automatic int tag_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_pack_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; priority pointer advances past the winner only on a grant.
`timescale 1ns/1ps
module fifo_pack_rr_arbiter
  import fifo_pack_pkg::*;
#(
  parameter int p_num_reqs = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_num_reqs-1:0]         req,
  input  logic                          en,
  output logic [p_num_reqs-1:0]         grant,
  output logic [$clog2(p_num_reqs)-1:0] grant_idx
);

  localparam int IW = tag_width(p_num_reqs);

  logic [IW-1:0] ptr;
  logic [IW-1:0] k;
  logic          found;

  // Walk ptr, ptr+1, ... with explicit wrap so non-power-of-two counts work.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = ptr;
    for (int unsigned o = 0; o < p_num_reqs; o++) begin
      if (!found && req[k]) begin
        found     = 1'b1;
        grant_idx = k;
      end
      k = (k == IW'(p_num_reqs - 1)) ? '0 : k + 1'b1;
    end
    if (found && en) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (|grant)
      ptr <= (grant_idx == IW'(p_num_reqs - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/fifo_pack_arbiter.sv
// Packs one of p_num_reqs narrow messages into a left-aligned FIFO word behind a one-entry output register.
// Define FIFO_PACK_ARB_SRC_TAG_EN to carry the granted requester index in the low pad bits.
`timescale 1ns/1ps
module fifo_pack_arbiter
  import fifo_pack_pkg::*;
#(
  parameter int p_bit_width      = 3,
  parameter int p_full_bit_width = 6,
  parameter int p_num_reqs       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs*p_bit_width-1:0] req_msg,
  input  logic [p_num_reqs-1:0]             req_val,
  output logic [p_num_reqs-1:0]             req_rdy,
  output logic [p_full_bit_width-1:0]       resp_msg,
  output logic                              resp_val,
  input  logic                              resp_rdy
);

  localparam int P  = pad_width(p_full_bit_width, p_bit_width);
  localparam int TW = tag_width(p_num_reqs);

  if (P < 0) begin : g_bad_pad
    $error("fifo_pack_arbiter: p_full_bit_width smaller than p_bit_width");
  end
  if (p_num_reqs < 2) begin : g_bad_reqs
    $error("fifo_pack_arbiter: p_num_reqs must be at least 2");
  end
`ifdef FIFO_PACK_ARB_SRC_TAG_EN
  if (P < TW) begin : g_bad_tag
    $error("fifo_pack_arbiter: pad too narrow for source tag");
  end
`endif

  out_state_t                  state;
  logic                        can_accept;
  logic [p_num_reqs-1:0]       grant;
  logic [TW-1:0]               grant_idx;
  logic [p_bit_width-1:0]      sel_msg;
  logic [p_full_bit_width-1:0] pack_word;

  // Reset gates the enable so requesters never see a grant while in reset.
  assign can_accept = !reset && ((state == EMPTY) || resp_rdy);

  fifo_pack_rr_arbiter #(
    .p_num_reqs (p_num_reqs)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_val),
    .en        (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_rdy  = grant;
  assign resp_val = (state == FULL);

  always_comb begin
    sel_msg   = req_msg[32'(grant_idx) * p_bit_width +: p_bit_width];
    pack_word = '0;
    pack_word[p_full_bit_width-1 -: p_bit_width] = sel_msg;
`ifdef FIFO_PACK_ARB_SRC_TAG_EN
    pack_word[TW-1:0] = grant_idx;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      resp_msg <= '0;
    end else if (|grant) begin
      state    <= FULL;
      resp_msg <= pack_word;
    end else if (resp_rdy) begin
      state    <= EMPTY;
    end
  end

endmodule

// File: tb/tb_fifo_pack_arbiter.sv
// Directed self-checking bench for fifo_pack_arbiter (N=4, 3-bit messages, 6-bit words).
`timescale 1ns/1ps
module tb_fifo_pack_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] req_msg;
  logic [3:0]  req_val;
  logic [3:0]  req_rdy;
  logic [5:0]  resp_msg;
  logic        resp_val;
  logic        resp_rdy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_pack_arbiter #(
    .p_bit_width      (3),
    .p_full_bit_width (6),
    .p_num_reqs       (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_msg  (req_msg),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .resp_msg (resp_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pk(input logic [2:0] m, input logic [1:0] i);
`ifdef FIFO_PACK_ARB_SRC_TAG_EN
    return {m, 1'b0, i};
`else
    return {m, 3'b000};
`endif
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] m;
    logic [1:0] ix;

    reset    = 1'b1;
    req_val  = 4'b1111;
    req_msg  = {3'd4, 3'd3, 3'd2, 3'd1};
    resp_rdy = 1'b1;

    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_val", 32'(resp_val), 32'd0);
      check("rst_msg", 32'(resp_msg), 32'd0);
      check("rst_rdy", 32'(req_rdy), 32'd0);
    end

    // Round-robin with all valid: 0,1,2,3,0,1 with no bubbles.
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_rdy", 32'(req_rdy), 32'(4'b0001 << (c % 4)));
      tick();
      ix = 2'(c % 4);
      m  = 3'(c % 4 + 1);
      check("rr_val", 32'(resp_val), 32'd1);
      check("rr_msg", 32'(resp_msg), 32'(pk(m, ix)));
    end

    // Backpressure: word from requester 1 held, ptr stays at 2.
    resp_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rdy", 32'(req_rdy), 32'd0);
      tick();
      check("bp_val", 32'(resp_val), 32'd1);
      check("bp_msg", 32'(resp_msg), 32'(pk(3'd2, 2'd1)));
    end
    resp_rdy = 1'b1;
    #1;
    check("rel_rdy", 32'(req_rdy), 32'b0100);
    tick();
    check("rel_msg", 32'(resp_msg), 32'(pk(3'd3, 2'd2)));

    // Single requester 2 with 3'b101.
    req_val = 4'b0100;
    req_msg = {3'd4, 3'b101, 3'd2, 3'd1};
    #1;
    check("one_rdy", 32'(req_rdy), 32'b0100);
    tick();
    check("one_val", 32'(resp_val), 32'd1);
    check("one_msg", 32'(resp_msg), 32'(pk(3'b101, 2'd2)));

    // Nothing valid: register drains.
    req_val = 4'b0000;
    #1;
    check("idle_rdy", 32'(req_rdy), 32'd0);
    tick();
    check("idle_val", 32'(resp_val), 32'd0);

    // Wrap/skip: only 3 and 0 valid, ptr currently 3.
    req_val = 4'b1001;
    req_msg = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int c = 0; c < 4; c++) begin
      #1;
      check("wrap_rdy", 32'(req_rdy), (c % 2 == 0) ? 32'b1000 : 32'b0001);
      tick();
      check("wrap_msg", 32'(resp_msg),
            (c % 2 == 0) ? 32'(pk(3'd4, 2'd3)) : 32'(pk(3'd1, 2'd0)));
    end

    // Load a word from requester 1 so ptr becomes 2, then stall and reset.
    req_val = 4'b0010;
    tick();
    check("pre_msg", 32'(resp_msg), 32'(pk(3'd2, 2'd1)));
    resp_rdy = 1'b0;
    req_val  = 4'b1010;
    #1;
    check("stall_rdy", 32'(req_rdy), 32'd0);
    reset = 1'b1;
    #1;
    check("mrst_rdy", 32'(req_rdy), 32'd0);
    tick();
    check("mrst_val", 32'(resp_val), 32'd0);
    check("mrst_msg", 32'(resp_msg), 32'd0);
    reset    = 1'b0;
    resp_rdy = 1'b1;
    #1;
    check("post_rdy", 32'(req_rdy), 32'b0010);
    tick();
    check("post_val", 32'(resp_val), 32'd1);
    check("post_msg", 32'(resp_msg), 32'(pk(3'd2, 2'd1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
